// File: rtl/uart_dl_pkt_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_dl_pkt_rx
// Purpose  : Download-packet receiver sitting behind the UART RX byte engine.
//            It assembles seq + payload + CRC16 packets, checks the CRC-16/MODBUS
//            and the sequence number, writes the payload to instruction memory
//            as little-endian 32-bit words, and returns a one-byte ACK/NAK.
//            Optional packet/error counters are included when UART_DL_STATS_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_dl_pkt_rx #(
    parameter int                PKT_DATA_BYTES = 32,
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                TIMEOUT_CYC    = 50000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              tx_valid_o,
    output logic [7:0]        tx_data_o,
    input  logic              tx_ready_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    output logic              busy_o,
    output logic              pkt_ok_o,
    output logic              crc_err_o
`ifdef UART_DL_STATS_EN
    ,
    output logic [15:0]       pkt_cnt_o,
    output logic [15:0]       err_cnt_o
`endif
);

    localparam int NWORDS    = PKT_DATA_BYTES / 4;
    localparam int PKT_BYTES = PKT_DATA_BYTES + 3;
    localparam int CNT_W     = $clog2(PKT_BYTES);
    localparam int BIDX_W    = $clog2(PKT_DATA_BYTES);
    localparam int WORD_W    = $clog2(NWORDS + 1);
    localparam int TO_W      = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0]  CNT_PAY_LAST = CNT_W'(PKT_DATA_BYTES);
    localparam logic [CNT_W-1:0]  CNT_CRC_LO   = CNT_W'(PKT_DATA_BYTES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(PKT_BYTES - 1);
    localparam logic [WORD_W-1:0] WORD_LAST    = WORD_W'(NWORDS - 1);
    localparam logic [TO_W-1:0]   TO_LAST      = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]        ACK          = 8'h06;
    localparam logic [7:0]        NAK          = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_CHECK = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              state_q;
    logic [7:0]          seq_q;
    logic [7:0]          exp_seq_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [15:0]         crc_q;
    logic [15:0]         crc_rx_q;
    logic [WORD_W-1:0]   word_q;
    logic [TO_W-1:0]     idle_q;
    logic [7:0]          buf_q [PKT_DATA_BYTES];
    logic                tx_valid_q;
    logic [7:0]          tx_data_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic                pkt_ok_q;
    logic                crc_err_q;

    logic [15:0]         crc_d;
    logic [WORD_W-1:0]   word_d;
    logic [WORD_W-1:0]   wsel_d;
    logic [31:0]         wdata_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [BIDX_W-1:0]   bidx_d;
    logic                crc_bad_d;
    logic                seq_new_d;
    logic                seq_dup_d;
    logic                last_word_d;
    logic                pkt_ok_d;
    logic                nak_d;
    logic                timeout_d;

    // One byte of CRC-16/MODBUS (reflected poly 0xA001), all 8 bit-steps at once.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] b);
        logic [15:0] c;
        c = crc_in ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Next CRC, next write word/address/data and the CHECK/WRITE decisions.
    always_comb begin
        crc_d       = crc16_byte((state_q == S_IDLE) ? 16'hFFFF : crc_q, rx_data_i);
        word_d      = (state_q == S_WRITE) ? (word_q + 1'b1) : '0;
        wsel_d      = (word_d > WORD_LAST) ? '0 : word_d;
        wdata_d     = '0;
        for (int i = 0; i < 4; i++) begin
            wdata_d[8*i +: 8] = buf_q[BIDX_W'(int'(wsel_d) * 4 + i)];
        end
        addr_d      = BASE_ADDR + ADDR_W'(seq_q) * ADDR_W'(PKT_DATA_BYTES) + (ADDR_W'(word_d) << 2);
        bidx_d      = BIDX_W'(cnt_q - 1'b1);
        crc_bad_d   = (crc_q != crc_rx_q);
        seq_new_d   = (seq_q == exp_seq_q);
        seq_dup_d   = (seq_q == (exp_seq_q - 8'd1));
        last_word_d = (word_q == WORD_LAST);
        pkt_ok_d    = ((state_q == S_CHECK) && !crc_bad_d && !seq_new_d && seq_dup_d) ||
                      ((state_q == S_WRITE) && mem_ready_i && last_word_d);
        nak_d       = (state_q == S_CHECK) && (crc_bad_d || !(seq_new_d || seq_dup_d));
        timeout_d   = (state_q == S_RECV) && !rx_valid_i && (idle_q == TO_LAST);
    end

    // Payload buffer capture; contents are only meaningful after a full packet.
    always_ff @(posedge clk_i) begin
        if (en_i && (state_q == S_RECV) && rx_valid_i && (cnt_q <= CNT_PAY_LAST)) begin
            buf_q[bidx_d] <= rx_data_i;
        end
    end

    // Packet FSM with registered outputs; en_i low aborts everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            seq_q       <= '0;
            exp_seq_q   <= '0;
            cnt_q       <= '0;
            crc_q       <= 16'hFFFF;
            crc_rx_q    <= '0;
            word_q      <= '0;
            idle_q      <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            pkt_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
        end else if (!en_i) begin
            state_q     <= S_IDLE;
            exp_seq_q   <= '0;
            cnt_q       <= '0;
            crc_q       <= 16'hFFFF;
            word_q      <= '0;
            idle_q      <= '0;
            tx_valid_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            pkt_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
        end else begin
            pkt_ok_q  <= pkt_ok_d;
            crc_err_q <= (state_q == S_CHECK) && crc_bad_d;
            case (state_q)
                S_IDLE: begin
                    if (rx_valid_i) begin
                        seq_q   <= rx_data_i;
                        crc_q   <= crc_d;
                        cnt_q   <= CNT_W'(1);
                        idle_q  <= '0;
                        state_q <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (rx_valid_i) begin
                        idle_q <= '0;
                        if (cnt_q <= CNT_PAY_LAST) begin
                            crc_q <= crc_d;
                        end else if (cnt_q == CNT_CRC_LO) begin
                            crc_rx_q[7:0] <= rx_data_i;
                        end else begin
                            crc_rx_q[15:8] <= rx_data_i;
                        end
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= S_CHECK;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (timeout_d) begin
                        // Partial packet abandoned silently.
                        cnt_q   <= '0;
                        crc_q   <= 16'hFFFF;
                        idle_q  <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    crc_q <= 16'hFFFF;
                    if (!crc_bad_d && seq_new_d) begin
                        word_q      <= '0;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= wdata_d;
                        state_q     <= S_WRITE;
                    end else begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= nak_d ? NAK : ACK;
                        state_q    <= S_RESP;
                    end
                end
                S_WRITE: begin
                    if (mem_ready_i) begin
                        if (last_word_d) begin
                            mem_we_q   <= 1'b0;
                            exp_seq_q  <= exp_seq_q + 8'd1;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= ACK;
                            state_q    <= S_RESP;
                        end else begin
                            word_q      <= word_d;
                            mem_addr_q  <= addr_d;
                            mem_wdata_q <= wdata_d;
                        end
                    end
                end
                S_RESP: begin
                    if (tx_ready_i) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_valid_o  = tx_valid_q;
    assign tx_data_o   = tx_data_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (state_q != S_IDLE);
    assign pkt_ok_o    = pkt_ok_q;
    assign crc_err_o   = crc_err_q;

`ifdef UART_DL_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] err_cnt_q;

    // Saturating accepted-packet and NAK/timeout counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (!en_i) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (pkt_ok_d && (pkt_cnt_q != 16'hFFFF)) begin
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            end
            if ((nak_d || timeout_d) && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
    assign err_cnt_o = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_dl_pkt_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_dl_pkt_rx
// Purpose  : Scoreboard bench for uart_dl_pkt_rx. Stimulus pushes expected
//            memory writes and response bytes into queues; a monitor pops and
//            compares them whenever the DUT presents a handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_dl_pkt_rx;

    localparam int TO_CYC = 300;

    typedef logic [7:0] pl_t [32];
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_ready = 1'b1;
    logic        mem_ready = 1'b1;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        busy_o;
    logic        pkt_ok_o;
    logic        crc_err_o;

    int checks = 0;
    int errors = 0;
    int pkt_ok_seen = 0;
    int crc_err_seen = 0;
    bit stall_mode = 1'b0;

    wr_t        wr_q[$];
    logic [7:0] tx_q[$];

    uart_dl_pkt_rx #(
        .PKT_DATA_BYTES(32),
        .ADDR_W(32),
        .BASE_ADDR(32'h0),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .tx_valid_o (tx_valid_o),
        .tx_data_o  (tx_data_o),
        .tx_ready_i (tx_ready),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready),
        .busy_o     (busy_o),
        .pkt_ok_o   (pkt_ok_o),
        .crc_err_o  (crc_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            if (r[0]) r = (r >> 1) ^ 16'hA001;
            else      r = r >> 1;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory ready: either always ready, or 3 stall cycles per presented word.
    initial begin
        int wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!stall_mode) begin
                mem_ready = 1'b1;
                wcnt = 0;
            end else if (mem_we_o) begin
                if (wcnt == 3) begin
                    mem_ready = 1'b1;
                    wcnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: compares every write/response handshake against the queues.
    initial begin
        bit          stalled = 1'b0;
        logic [31:0] prev_a = '0;
        logic [31:0] prev_d = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_we_o) begin
                    if (stalled) begin
                        check("stall_addr_hold", mem_addr_o, prev_a);
                        check("stall_data_hold", mem_wdata_o, prev_d);
                    end
                    if (mem_ready) begin
                        checks++;
                        if (wr_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", mem_addr_o, mem_wdata_o);
                        end else begin
                            wr_t e;
                            e = wr_q.pop_front();
                            if (mem_addr_o !== e.a || mem_wdata_o !== e.d) begin
                                errors++;
                                $display("FAIL mem_write: got addr 0x%08h data 0x%08h expected addr 0x%08h data 0x%08h",
                                         mem_addr_o, mem_wdata_o, e.a, e.d);
                            end
                        end
                    end
                    stalled = !mem_ready;
                    prev_a  = mem_addr_o;
                    prev_d  = mem_wdata_o;
                end else begin
                    stalled = 1'b0;
                end
                if (tx_valid_o && tx_ready) begin
                    checks++;
                    if (tx_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_tx: got 0x%02h, none expected", tx_data_o);
                    end else begin
                        logic [7:0] et;
                        et = tx_q.pop_front();
                        if (tx_data_o !== et) begin
                            errors++;
                            $display("FAIL tx_byte: got 0x%02h expected 0x%02h", tx_data_o, et);
                        end
                    end
                end
                if (pkt_ok_o)  pkt_ok_seen++;
                if (crc_err_o) crc_err_seen++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] seq, input pl_t pl, input bit bad_crc);
        logic [15:0] c;
        c = crc_upd(16'hFFFF, seq);
        send_byte(seq);
        for (int i = 0; i < 32; i++) begin
            c = crc_upd(c, pl[i]);
            send_byte(pl[i]);
        end
        send_byte(bad_crc ? (c[7:0] ^ 8'hFF) : c[7:0]);
        send_byte(c[15:8]);
    endtask

    task automatic push_writes(input logic [7:0] seq, input pl_t pl);
        for (int k = 0; k < 8; k++) begin
            wr_t e;
            e.a = 32'(seq) * 32 + 32'(4 * k);
            e.d = {pl[4*k+3], pl[4*k+2], pl[4*k+1], pl[4*k]};
            wr_q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((wr_q.size() != 0 || tx_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s_drain: %0d writes and %0d tx still pending, expected 0", name, wr_q.size(), tx_q.size());
        end
        check({name, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        pl_t p1, p3, p5, p6, pd, pf;
        for (int i = 0; i < 32; i++) begin
            p1[i] = 8'h00;
            p3[i] = 8'(i + 16);
            p5[i] = 8'hA0 ^ 8'(i);
            p6[i] = 8'(i * 3);
            pd[i] = 8'h55;
            pf[i] = 8'hF0 - 8'(i);
        end
        p1[0] = 8'h01; p1[1] = 8'h02; p1[2] = 8'h03;

        repeat (3) @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
        check("rst_tx_data",  32'(tx_data_o),  32'd0);
        check("rst_mem_we",   32'(mem_we_o),   32'd0);
        check("rst_mem_addr", mem_addr_o,      32'd0);
        check("rst_mem_wdata", mem_wdata_o,    32'd0);
        check("rst_busy",     32'(busy_o),     32'd0);
        check("rst_pkt_ok",   32'(pkt_ok_o),   32'd0);
        check("rst_crc_err",  32'(crc_err_o),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Bytes while disabled are ignored.
        send_byte(8'h00);
        @(negedge clk);
        check("dis_busy", 32'(busy_o), 32'd0);
        en = 1'b1;

        // 1: seq 0 new packet, hand-computed words.
        wr_q.push_back('{32'h00, 32'h00030201});
        for (int k = 1; k < 8; k++) wr_q.push_back('{32'(4 * k), 32'h0});
        tx_q.push_back(8'h06);
        send_pkt(8'd0, p1, 1'b0);
        drain("t1");
        check("t1_pkt_ok", 32'(pkt_ok_seen), 32'd1);

        // 2: duplicate seq 0 -> ACK, no writes.
        tx_q.push_back(8'h06);
        send_pkt(8'd0, p1, 1'b0);
        drain("t2");
        check("t2_pkt_ok", 32'(pkt_ok_seen), 32'd2);

        // 3: seq 1 with bad CRC, then correct.
        tx_q.push_back(8'h15);
        send_pkt(8'd1, p3, 1'b1);
        drain("t3a");
        check("t3_crc_err", 32'(crc_err_seen), 32'd1);
        check("t3a_pkt_ok", 32'(pkt_ok_seen), 32'd2);
        push_writes(8'd1, p3);
        tx_q.push_back(8'h06);
        send_pkt(8'd1, p3, 1'b0);
        drain("t3b");
        check("t3b_pkt_ok", 32'(pkt_ok_seen), 32'd3);

        // 4: out-of-order seq 5 -> NAK, no CRC error.
        tx_q.push_back(8'h15);
        send_pkt(8'd5, p3, 1'b0);
        drain("t4");
        check("t4_crc_err", 32'(crc_err_seen), 32'd1);
        check("t4_pkt_ok", 32'(pkt_ok_seen), 32'd3);

        // 5: fragment then timeout, then seq 2.
        for (int i = 0; i < 10; i++) send_byte(8'(i + 2));
        check("t5_frag_busy", 32'(busy_o), 32'd1);
        repeat (TO_CYC + 5) @(negedge clk);
        check("t5_timeout_busy", 32'(busy_o), 32'd0);
        push_writes(8'd2, p5);
        tx_q.push_back(8'h06);
        send_pkt(8'd2, p5, 1'b0);
        drain("t5");
        check("t5_pkt_ok", 32'(pkt_ok_seen), 32'd4);

        // 6a: stalled memory, seq 3 at 0x60.
        stall_mode = 1'b1;
        push_writes(8'd3, p6);
        tx_q.push_back(8'h06);
        send_pkt(8'd3, p6, 1'b0);
        drain("t6a");
        check("t6a_pkt_ok", 32'(pkt_ok_seen), 32'd5);

        // 6b: drop en_i during WRITE of seq 4.
        begin
            int n = 0;
            send_pkt(8'd4, pd, 1'b0);
            while (!mem_we_o && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("t6b_we_seen", 32'(mem_we_o), 32'd1);
            en = 1'b0;
            @(negedge clk);
            check("t6b_we_cleared", 32'(mem_we_o), 32'd0);
            check("t6b_busy", 32'(busy_o), 32'd0);
            check("t6b_tx_valid", 32'(tx_valid_o), 32'd0);
            stall_mode = 1'b0;
            @(negedge clk);
            en = 1'b1;
        end
        push_writes(8'd0, pf);
        tx_q.push_back(8'h06);
        send_pkt(8'd0, pf, 1'b0);
        drain("t6c");
        check("t6c_pkt_ok", 32'(pkt_ok_seen), 32'd6);
        check("final_crc_err", 32'(crc_err_seen), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/uart_dl_pkt_rx.md
Name: uart_dl_pkt_rx

Overview:
Download-packet receiver that sits directly downstream of the UART RX byte engine, active while the download-enable pin is asserted.
- Assembles 35-byte download packets: seq(1) + payload(32) + CRC16(2).
- Checks CRC and sequence, writes the payload as 32-bit words into instruction memory, and returns a one-byte ACK/NAK to the UART TX engine.
- Feeds the memory write port; the host tool retransmits on NAK.

Parameters:
PKT_DATA_BYTES, 32, payload bytes per packet (multiple of 4)
ADDR_W, 32, memory address width
BASE_ADDR, 0, address of payload byte 0 of seq 0
TIMEOUT_CYC, 50000, inter-byte idle cycles before a partial packet is discarded

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
en_i  in  1  download enable (from debug pin, already synchronised)
rx_valid_i  in  1  one-cycle strobe, byte received
rx_data_i  in  8  received byte
tx_valid_o  out  1  response byte valid
tx_data_o  out  8  response byte (0x06 ACK, 0x15 NAK)
tx_ready_i  in  1  TX engine accepts byte
mem_we_o  out  1  word write request
mem_addr_o  out  ADDR_W  byte address, word aligned
mem_wdata_o  out  32  write data
mem_ready_i  in  1  memory accepts write
busy_o  out  1  high in any state other than IDLE
pkt_ok_o  out  1  one-cycle pulse, packet accepted (new or duplicate)
crc_err_o  out  1  one-cycle pulse, CRC mismatch

Behaviour:
- Reset: every output is 0, FSM is IDLE, expected_seq is 0, byte counter is 0, CRC register is 0xFFFF.
- FSM states: IDLE, RECV, CHECK, WRITE, RESP.
- IDLE:
  - On rx_valid_i with en_i=1: store the byte as seq, seed CRC, go to RECV.
  - rx_valid_i with en_i=0 is ignored.
- RECV:
  - Store bytes 1..PKT_DATA_BYTES in the payload buffer.
  - Store the last 2 bytes as crc_rx, low byte first.
  - CRC is updated the same cycle as each seq/payload byte, not over the CRC bytes.
  - After the final byte, go to CHECK.
- CRC algorithm: CRC-16/MODBUS (reflected poly 0xA001, init 0xFFFF, no final xor), 8 bit-steps per byte in one cycle.
- Timeout: an idle counter resets on every byte. If it reaches TIMEOUT_CYC in RECV, discard the packet, go to IDLE, send no response.
- CHECK (1 cycle):
  - CRC mismatch: NAK, pulse crc_err_o, go to RESP.
  - seq == expected_seq: go to WRITE.
  - seq == expected_seq-1 (mod 256, duplicate/retransmit): ACK without writing, pulse pkt_ok_o.
  - Any other seq: NAK.
- WRITE:
  - Issue PKT_DATA_BYTES/4 writes.
  - Word k: mem_addr_o = BASE_ADDR + seq*PKT_DATA_BYTES + 4k.
  - Data is little-endian: payload byte 4k goes to bits[7:0].
  - mem_we_o, addr and data are held until mem_ready_i is sampled high, then advance.
  - After the last word: increment expected_seq (8-bit wrap 255->0), pulse pkt_ok_o, load ACK, go to RESP.
- RESP:
  - tx_valid_o=1 with tx_data_o stable until tx_ready_i is high.
  - The handshake cycle clears tx_valid_o and returns to IDLE.
- Bytes arriving in CHECK/WRITE/RESP are dropped.
- en_i deasserted in any state:
  - Next cycle: FSM to IDLE, mem_we_o and tx_valid_o cleared, expected_seq reset to 0.
  - A write in flight is abandoned; the host must restart the download.
- Latency: last byte to first mem_we_o is 2 cycles (RECV->CHECK->WRITE). Zero-wait memory gives 8 write cycles for the default payload.

Optional Feature:
UART_DL_STATS_EN
- Defined: adds outputs pkt_cnt_o[15:0] and err_cnt_o[15:0].
  - pkt_cnt_o increments on each pkt_ok_o.
  - err_cnt_o increments on each NAK or timeout.
  - Both counters saturate at 0xFFFF.
  - Both clear on rst_i and on en_i low.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Send seq 0 with payload 01 02 03 00.. and golden-model CRC.
   -> 8 writes; addr 0x00 data 0x00030201, addr 0x04..0x1C data 0; then tx 0x06; expected_seq becomes 1.
2. Repeat the same seq 0 packet.
   -> no mem_we_o; tx 0x06; pkt_ok_o pulses; expected_seq stays 1.
3. Send seq 1 with the CRC low byte flipped.
   -> crc_err_o pulse; tx 0x15; no writes. Resend correctly -> writes at 0x20..0x3C; ACK.
4. Send seq 5 while expected is 2.
   -> tx 0x15; no writes; expected_seq unchanged.
5. Send 10 bytes, then idle for TIMEOUT_CYC cycles, then a valid seq 2 packet.
   -> no response to the fragment; seq 2 is written at 0x40 and ACKed.
6. Hold mem_ready_i low 3 cycles per word, and separately drop en_i mid-WRITE.
   -> addr/data are stable while stalled; on en_i low, mem_we_o is 0 next cycle, busy_o is 0, and seq 0 is accepted afterward.
